// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: ID/EX stall/flush sequencing for load-use, EX redirects and multi-cycle FPU ops,
// plus a saturating stall-cycle performance counter.
module ex_hazard_ctrl #(
   parameter int unsigned REGFILE_LEN = 6,
   parameter int unsigned FPU_OP_WIDTH = 6,
   parameter logic [FPU_OP_WIDTH-1:0] FPU_DIV_OP = 6'd3,
   parameter logic [FPU_OP_WIDTH-1:0] FPU_SQRT_OP = 6'd11,
   parameter int unsigned DIV_CYCLES = 16,
   parameter int unsigned SQRT_CYCLES = 20,
   parameter int unsigned CNT_WIDTH = 5,
   parameter int unsigned PERF_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REGFILE_LEN-1:0]  id_rs1,
   input  logic [REGFILE_LEN-1:0]  id_rs2,
   input  logic                    id_uses_rs1,
   input  logic                    id_uses_rs2,
   input  logic [REGFILE_LEN-1:0]  ex_rd,
   input  logic                    ex_mem_read,
   input  logic                    ex_alu_fpu,
   input  logic [FPU_OP_WIDTH-1:0] ex_fpu_op,
   input  logic                    ex_redirect,
   output logic                    pc_stall,
   output logic                    if_id_stall,
   output logic                    if_id_flush,
   output logic                    id_ex_stall,
   output logic                    id_ex_flush,
   output logic                    ex_mem_bubble,
   output logic                    fpu_done,
   output logic                    fpu_busy,
   output logic [PERF_WIDTH-1:0]   stall_cycles
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [PERF_WIDTH-1:0] perf_q, perf_d;
   logic is_div, long_op, idle, start, busy_hold, busy_done, hold, redir, hazard, lu;
   assign is_div    = ex_fpu_op == FPU_DIV_OP;
   assign long_op   = ex_alu_fpu & (is_div | ex_fpu_op == FPU_SQRT_OP);
   assign idle      = state_q == IDLE;
   assign start     = idle & long_op;
   assign busy_hold = state_q == BUSY & cnt_q != '0;
   assign busy_done = state_q == BUSY & cnt_q == '0;
   assign hold      = start | busy_hold;
   assign hazard    = ex_mem_read & ex_rd != '0 &
                      ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd));
   // Redirect outranks load-use; neither applies while EX holds an FPU op.
   assign redir     = idle & ~long_op & ex_redirect;
   assign lu        = idle & ~long_op & ~ex_redirect & hazard;
   assign pc_stall      = ~rst & (hold | lu);
   assign if_id_stall   = ~rst & (hold | lu);
   assign if_id_flush   = ~rst & redir;
   assign id_ex_stall   = ~rst & hold;
   assign id_ex_flush   = ~rst & (redir | lu);
   assign ex_mem_bubble = ~rst & hold;
   assign fpu_done      = ~rst & busy_done;
   assign fpu_busy      = ~rst & state_q == BUSY;
   assign stall_cycles  = perf_q;
   always_comb begin
      state_d = start ? BUSY : busy_done ? IDLE : state_q;
      cnt_d   = start ? CNT_WIDTH'(is_div ? DIV_CYCLES - 2 : SQRT_CYCLES - 2) :
                busy_hold ? cnt_q - 1'b1 : cnt_q;
      perf_d  = (pc_stall & perf_q != '1) ? perf_q + 1'b1 : perf_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed vectors with a queued scoreboard for ex_hazard_ctrl,
// including a PERF_WIDTH=4 instance for counter saturation.
module tb_ex_hazard_ctrl;
   logic clk = 1'b1;
   logic rst;
   logic [5:0] id_rs1, id_rs2, ex_rd, ex_fpu_op;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_alu_fpu, ex_redirect;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, fpu_done, fpu_busy;
   logic [31:0] stall_cycles;
   logic s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush, s_ex_mem_bubble, s_fpu_done, s_fpu_busy;
   logic [3:0] s_stall_cycles;

   typedef struct packed {
      logic [7:0]  c;
      logic [31:0] p;
      logic [3:0]  s;
   } exp_t;
   exp_t q[$];
   logic [31:0] exp_perf;
   logic [3:0] exp_sat;
   int n_chk = 0, n_err = 0;
   bit done = 0;

   // control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, fpu_done, fpu_busy
   localparam logic [7:0] NONE = 8'h00, START = 8'hD4, BUSY = 8'hD5, DONE = 8'h03, LU = 8'hC8, RED = 8'h28;

   always #5 clk = ~clk;

   ex_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_alu_fpu(ex_alu_fpu),
      .ex_fpu_op(ex_fpu_op), .ex_redirect(ex_redirect), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_bubble(ex_mem_bubble), .fpu_done(fpu_done), .fpu_busy(fpu_busy), .stall_cycles(stall_cycles)
   );

   ex_hazard_ctrl #(.PERF_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_alu_fpu(ex_alu_fpu),
      .ex_fpu_op(ex_fpu_op), .ex_redirect(ex_redirect), .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
      .if_id_flush(s_if_id_flush), .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
      .ex_mem_bubble(s_ex_mem_bubble), .fpu_done(s_fpu_done), .fpu_busy(s_fpu_busy), .stall_cycles(s_stall_cycles)
   );

   task automatic cyc(input logic [7:0] e);
      if (rst) begin
         exp_perf = 0;
         exp_sat = 0;
      end
      q.push_back(exp_t'{c: e, p: exp_perf, s: exp_sat});
      if (e[7]) begin
         exp_perf++;
         if (exp_sat != 4'hF) exp_sat++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic long_op(input logic [5:0] op, input int n);
      ex_alu_fpu = 1;
      ex_fpu_op = op;
      cyc(START);
      repeat (n - 2) cyc(BUSY);
      cyc(DONE);
      ex_alu_fpu = 0;
      ex_fpu_op = 0;
   endtask

   initial begin
      exp_t e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, fpu_done, fpu_busy};
            n_chk += 3;
            if (act !== e.c) begin
               n_err++;
               $display("FAIL ctrl t=%0t got %b expected %b", $time, act, e.c);
            end
            if (stall_cycles !== e.p) begin
               n_err++;
               $display("FAIL stall_cycles t=%0t got %0d expected %0d", $time, stall_cycles, e.p);
            end
            if (s_stall_cycles !== e.s) begin
               n_err++;
               $display("FAIL stall_cycles_sat t=%0t got %0d expected %0d", $time, s_stall_cycles, e.s);
            end
         end
      end
   end

   initial begin
      rst = 1;
      {id_rs1, id_rs2, ex_rd, ex_fpu_op} = '0;
      {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_alu_fpu, ex_redirect} = '0;
      exp_perf = 0;
      exp_sat = 0;
      cyc(NONE);
      rst = 0;
      cyc(NONE);
      // load-use on rs1: one bubble, then EX holds the bubble
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
      cyc(LU);
      ex_mem_read = 0;
      cyc(NONE);
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
      cyc(NONE);
      ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 0;
      cyc(NONE);
      id_rs2 = 5; id_uses_rs2 = 1;
      cyc(LU);
      ex_redirect = 1;
      cyc(RED);
      {ex_redirect, ex_mem_read, id_uses_rs2} = '0;
      cyc(NONE);
      ex_redirect = 1;
      cyc(RED);
      ex_redirect = 0;
      long_op(6'd3, 16);
      cyc(NONE);
      // redirect while busy is ignored
      ex_alu_fpu = 1; ex_fpu_op = 6'd3;
      cyc(START);
      repeat (3) cyc(BUSY);
      ex_redirect = 1;
      repeat (3) cyc(BUSY);
      ex_redirect = 0;
      repeat (8) cyc(BUSY);
      cyc(DONE);
      ex_alu_fpu = 0; ex_fpu_op = 0;
      cyc(NONE);
      // reset in cycle 5 of a divide
      ex_alu_fpu = 1; ex_fpu_op = 6'd3;
      cyc(START);
      repeat (3) cyc(BUSY);
      rst = 1;
      cyc(NONE);
      rst = 0; ex_alu_fpu = 0; ex_fpu_op = 0;
      cyc(NONE);
      cyc(NONE);
      // back-to-back sqrt then divide from a clean counter: 34 stalls, 4-bit copy saturates
      rst = 1;
      cyc(NONE);
      rst = 0;
      long_op(6'd11, 20);
      long_op(6'd3, 16);
      cyc(NONE);
      ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
      cyc(LU);
      ex_mem_read = 0;
      cyc(NONE);
      done = 1;
   end

   initial begin
      wait (done);
      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the ID/EX boundary. It generates the stall and flush controls for the PC, IF/ID and ID/EX pipeline registers. It covers three cases: load-use hazards, control redirects resolved in EX, and multi-cycle FPU operations that must hold EX for a fixed number of cycles. It sits beside the ID/EX register: it inspects the decoded operands in ID and the instruction latched in EX, and it also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
REGFILE_LEN, 6, width of register indices (integer and FP registers share one index space; index 0 is x0)
FPU_OP_WIDTH, 6, width of fpu_op encoding
FPU_DIV_OP, 6'd3, fpu_op code for FP divide (multi-cycle)
FPU_SQRT_OP, 6'd11, fpu_op code for FP square root (multi-cycle)
DIV_CYCLES, 16, total EX-occupancy cycles for divide; must be >= 2
SQRT_CYCLES, 20, total EX-occupancy cycles for sqrt; must be >= 2
CNT_WIDTH, 5, busy counter width; must hold max(DIV_CYCLES,SQRT_CYCLES)-2
PERF_WIDTH, 32, stall-cycle counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
id_rs1  input  REGFILE_LEN  source 1 index of instruction in ID
id_rs2  input  REGFILE_LEN  source 2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  REGFILE_LEN  destination of instruction in EX (ID/EX out_rd)
ex_mem_read  input  1  EX instruction is a load (ID/EX out_mem_read)
ex_alu_fpu  input  1  EX instruction uses FPU (ID/EX out_alu_fpu)
ex_fpu_op  input  FPU_OP_WIDTH  FPU opcode in EX (ID/EX out_fpu_op)
ex_redirect  input  1  EX resolved taken branch/jump this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID to bubble
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  load bubble into ID/EX (ORed into its rst)
ex_mem_bubble  output  1  EX/MEM captures bubble this cycle
fpu_done  output  1  multi-cycle FPU result valid this cycle
fpu_busy  output  1  FSM in BUSY
stall_cycles  output  PERF_WIDTH  saturating count of cycles with pc_stall=1

Behaviour:
- FSM states: IDLE, BUSY. Register CNT[CNT_WIDTH].
- long_op = ex_alu_fpu & (ex_fpu_op==FPU_DIV_OP | ex_fpu_op==FPU_SQRT_OP); N = DIV_CYCLES or SQRT_CYCLES accordingly.
- IDLE, long_op=1 (start): pc_stall=if_id_stall=id_ex_stall=ex_mem_bubble=1. At the clock edge: CNT<=N-2, state<=BUSY.
- BUSY, CNT!=0: same four stall outputs = 1; CNT decrements.
- BUSY, CNT==0: all stalls = 0, fpu_done=1; the pipeline advances at this edge; state<=IDLE.
- Net effect: a long op occupies EX exactly N cycles, with stall asserted for the first N-1 and fpu_done in cycle N. A back-to-back long op is detected in the following IDLE cycle.
- Load-use (IDLE and no start only): hazard = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Response: pc_stall=if_id_stall=1, id_ex_flush=1, id_ex_stall=0. This gives exactly one bubble, because the next cycle EX holds the bubble.
- Redirect (IDLE and no start): if_id_flush=1, id_ex_flush=1, with no stalls. Redirect overrides load-use; the load-use stall is suppressed.
- Priority: start/BUSY > redirect > load-use.
- ex_redirect is ignored in BUSY, since EX holds an FPU op.
- All control outputs are combinational from state, CNT and inputs. They are forced to 0 while rst=1.
- stall_cycles increments on each edge with pc_stall=1 and saturates at all-ones (no wrap).
- Reset (async, any time including mid-BUSY): state=IDLE, CNT=0, stall_cycles=0, all outputs 0. An aborted long op is not resumed; the reset also clears the pipeline registers.
- fpu_busy = (state==BUSY).

Test Plan:
- Reset mid-BUSY: start a divide, assert rst in cycle 5 → all outputs drop to 0 immediately; after release state=IDLE and stall_cycles=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1. Repeat with ex_rd=0, or with id_uses_rs1=0 → no stall.
- FP divide: ex_alu_fpu=1, ex_fpu_op=3 held while stalled → stalls high for 15 cycles, fpu_done=1 on cycle 16, stall_cycles=15.
- Back-to-back sqrt then divide → 19 stall cycles, done, then the divide is detected the next cycle (15 stalls, done); no lost or extra cycle; stall_cycles=34.
- Redirect with simultaneous load-use → if_id_flush=id_ex_flush=1, pc_stall=0. Redirect asserted during BUSY → ignored, stalls unchanged.
- Saturation with PERF_WIDTH=4: 20 stalled cycles → stall_cycles=15, holds at 15.
